// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, derived totals and the control-pipeline record.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int SYNC_ACT_LOW  = 0;
  localparam int SYNC_ACT_HIGH = 1;

  // One raster position's worth of control, carried alongside the ROM read.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic first;
  } ctl_t;

  function automatic int span_total(int act, int fp, int sw, int bp);
    return act + fp + sw + bp;
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Raster position counters plus the raw (undelayed) timing strobes.
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic active,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic first,
  output logic last
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_LO  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_HI  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_LO  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_HI  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  // hcnt free-runs across the line; vcnt steps on each line wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // Decode the current position into visible/sync/frame-boundary strobes.
  always_comb begin
    active    = (hcnt < H_ACT) && (vcnt < V_ACT);
    hsync_raw = (hcnt >= HS_LO) && (hcnt <= HS_HI);
    vsync_raw = (vcnt >= VS_LO) && (vcnt <= VS_HI);
    first     = (hcnt == '0) && (vcnt == '0);
    last      = (hcnt == H_LAST) && (vcnt == V_LAST);
  end

endmodule

// File: rtl/rom_pixel_fetch.sv
// ROM read initiator: raster timing, linear pixel address, 2-clk realignment.
module rom_pixel_fetch
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int SYNC_POL   = SYNC_ACT_LOW,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [DATA_WIDTH-1:0] rgb,
  output logic                  frame_start
);

  localparam logic SYNC_ON  = 1'(SYNC_POL);
  localparam logic SYNC_OFF = ~SYNC_ON;

  ctl_t ctl_raw;
  ctl_t ctl_d1;
  logic last;
  logic [ADDR_WIDTH-1:0] ptr;

  vga_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_tc (
    .clk      (clk),
    .rst      (rst),
    .active   (ctl_raw.active),
    .hsync_raw(ctl_raw.hs),
    .vsync_raw(ctl_raw.vs),
    .first    (ctl_raw.first),
    .last     (last)
  );

  assign addr = ptr;

  // Pixels are stored row-major with no padding, so counting visible
  // cycles gives vcnt*H_ACTIVE+hcnt without a multiplier.
  always_ff @(posedge clk) begin
    if (rst || last) ptr <= '0;
    else if (ctl_raw.active) ptr <= ptr + ADDR_WIDTH'(1);
  end

  // Stage 1: control waits here while the ROM produces rdata.
  always_ff @(posedge clk) begin
    if (rst) ctl_d1 <= '0;
    else     ctl_d1 <= ctl_raw;
  end

  // Stage 2: registered outputs; blanking forces rgb to 0 whatever the ROM returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
    end else begin
      de          <= ctl_d1.active;
      rgb         <= ctl_d1.active ? rdata : '0;
      frame_start <= ctl_d1.first;
      hsync       <= ctl_d1.hs ? SYNC_ON : SYNC_OFF;
      vsync       <= ctl_d1.vs ? SYNC_ON : SYNC_OFF;
    end
  end

endmodule

// File: tb/tb_rom_pixel_fetch.sv
// Bench for rom_pixel_fetch on a shrunk raster so several frames fit in a short run.
module tb_rom_pixel_fetch;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] addr;
  logic [23:0] rdata = '0;
  logic        hsync, vsync, de, frame_start;
  logic [23:0] rgb;

  logic [23:0] rom [0:127];

  int total = 0;
  int bad   = 0;
  int k     = 0;

  rom_pixel_fetch #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .ADDR_WIDTH(24), .DATA_WIDTH(24)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .rdata(rdata),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // synchronous ROM, one clock of read latency
  always @(posedge clk) rdata <= rom[addr[6:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  // Reference: everything follows from edges elapsed since reset released.
  always @(posedge clk) begin
    int p, h, v, ea;
    logic act;
    if (rst) k = 0; else k = k + 1;
    #1;
    p = k % FT; h = p % HT; v = p / HT;
    ea = (v < VA) ? v * HA + ((h < HA) ? h : HA) : VA * HA;
    chk("addr", 32'(addr), 32'(ea));
    if (k < 2) begin
      chk("de_rst", 32'(de), 0);
      chk("rgb_rst", 32'(rgb), 0);
      chk("fs_rst", 32'(frame_start), 0);
      chk("hs_rst", 32'(hsync), 1);
      chk("vs_rst", 32'(vsync), 1);
    end else begin
      p = (k - 2) % FT; h = p % HT; v = p / HT;
      act = (h < HA) && (v < VA);
      chk("de", 32'(de), 32'(act));
      chk("rgb", 32'(rgb), act ? 32'(rom[v * HA + h]) : 0);
      chk("fs", 32'(frame_start), 32'(p == 0));
      chk("hs", 32'(hsync), 32'(!(h >= HA + HF && h < HA + HF + HS)));
      chk("vs", 32'(vsync), 32'(!(v >= VA + VF && v < VA + VF + VS)));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst(input int n);
    @(negedge clk); rst = 1'b1;
    run(n);
    rst = 1'b0;
  endtask

  initial begin
    // phase A: ramp content, matches the address-plus-offset ROM
    for (int i = 0; i < 128; i++) rom[i] = 24'h100000 + 24'(i);
    rst = 1'b1;
    run(5);
    rst = 1'b0;
    run(2 * FT + 40);
    // short resets at random points, including mid-line and mid-frame
    for (int i = 0; i < 4; i++) begin
      pulse_rst(1);
      run($urandom_range(FT + 30, 10));
    end

    // phase B: saturated ROM, blanking must still read as 0
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 128; i++) rom[i] = 24'hFFFFFF;
    run(3);
    rst = 1'b0;
    run(FT + 50);

    // phase C: random content with random reset lengths
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 128; i++) rom[i] = 24'($urandom);
    run(2);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run($urandom_range(2 * FT, 5));
      pulse_rst($urandom_range(3, 1));
    end
    run(FT + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
